energy_echo_detect: RTL and testbench
=====================================

ENERGY_ECHO_DETECT -- requirements
Module: energy_echo_detect

Interface
REQ-001 Parameters SHALL be: E_W, default 24, energy input width; CNT_W, default 16, sample-index width; CONFIRM, default 4, consecutive qualifying samples needed to declare an echo (range 1..15).
REQ-002 Ports SHALL be:
- SYS_CLK  in  1  sole clock, rising edge
- RESET  in  1  synchronous active-high reset
- startPulse  in  1  transmit burst fired; begin time-of-flight window
- energyValid  in  1  inEnergy holds a new windowed sum-of-squares sample
- inEnergy  in  E_W  unsigned windowed energy
- threshOn  in  E_W  unsigned onset threshold
- threshOff  in  E_W  unsigned release threshold (threshOff <= threshOn)
- blankSamples  in  CNT_W  samples ignored after start (ring-down)
- timeoutSamples  in  CNT_W  window length in samples
- busy  out  1  FSM not IDLE
- tofValid  out  1  one-cycle pulse: echo declared
- tofCount  out  CNT_W  sample index of echo onset
- timeout  out  1  one-cycle pulse: window expired, no echo
- peakEnergy  out  E_W  maximum energy of the detected echo
- peakDone  out  1  one-cycle pulse: echo ended, peakEnergy final
REQ-003 One clock; reset is synchronous and active-high; all state SHALL change only on SYS_CLK rising edge.

Function
REQ-004 Sample index SHALL be 0 for the first energyValid after startPulse, incrementing by 1 per energyValid, saturating at all-ones.
REQ-005 States SHALL be IDLE, BLANK, SEARCH, CONFIRM, HOLD.
REQ-006 IDLE: energyValid ignored; startPulse -> BLANK (blankSamples != 0) or SEARCH (blankSamples == 0), index cleared.
REQ-007 Any state: startPulse SHALL abort and restart as REQ-006; no tofValid/timeout/peakDone pulse for the aborted run; a coincident energyValid is discarded.
REQ-008 Timeout check SHALL take priority: in BLANK/SEARCH/CONFIRM, a sample with index >= timeoutSamples -> timeout pulse next cycle, -> IDLE; sample not evaluated.
REQ-009 BLANK: samples with index < blankSamples ignored; the sample with index == blankSamples - 1 moves FSM to SEARCH.
REQ-010 SEARCH: sample with inEnergy >= threshOn -> record candidate = index, run = 1, peak = inEnergy; if CONFIRM == 1 declare (REQ-012), else -> CONFIRM.
REQ-011 CONFIRM: sample >= threshOff -> run += 1, peak = max; sample < threshOff -> SEARCH, candidate discarded.
REQ-012 Declaration when run reaches CONFIRM: tofCount <= candidate and tofValid = 1 for exactly one cycle, both registered (visible the cycle after the qualifying edge); -> HOLD.
REQ-013 HOLD: timeout inactive; sample >= threshOff updates peak = max; sample < threshOff -> peakEnergy <= peak, peakDone one-cycle pulse, -> IDLE.
REQ-014 Comparisons SHALL be unsigned, full E_W width, >= inclusive.
REQ-015 tofCount and peakEnergy SHALL hold until next update; busy = (state != IDLE), registered.

Reset
REQ-016 RESET SHALL force IDLE, index 0, run 0, candidate 0, peak 0, and outputs busy, tofValid, timeout, peakDone = 0, tofCount = 0, peakEnergy = 0; RESET overrides startPulse.
REQ-017 RESET mid-run SHALL abandon the run silently (no pulses).

Structure
REQ-018 Shared package SHALL hold the state enumeration and the E_W/CNT_W default constants, reused by the sum-of-squares datapath integration.
REQ-019 No sub-module; single module with FSM, index counter, run counter and peak register.

Verification
REQ-020 blank=10, timeout=100, threshOn=1000, threshOff=500, CONFIRM=4; energy 0 until index 30, 2000 at index 30..40, then 0 -> tofValid one cycle with tofCount=30 after index-33 sample; peakDone with peakEnergy=2000 after index-41 sample.
REQ-021 Same, energy 2000 only at indices 0..9 (inside blank) -> no tofValid; timeout pulse on index-100 sample.
REQ-022 Energy 2000 at 20..22, 0 at 23, 600 at 24..27 with 2000 at 24 -> first candidate dropped; tofCount=24 after index-27 sample.
REQ-023 startPulse during CONFIRM at index 50 -> no pulses; new index 0 next energyValid; normal detection follows.
REQ-024 RESET asserted in HOLD -> next cycle all outputs 0, busy=0; energyValid alone causes no activity.
REQ-025 blankSamples=0, CONFIRM=1, energy 1000 (== threshOn) at index 0 -> tofValid with tofCount=0 the cycle after that sample.

Source files
------------

// File: rtl/energy_echo_detect_pkg.sv
// Shared definitions for the echo-detection slice.
// Holds the detector state enumeration and the default energy / sample-index
// widths so the sum-of-squares datapath and the detector agree on sizes.
package energy_echo_detect_pkg;

   // Default width of the windowed sum-of-squares energy word.
   localparam int E_W_DEF   = 24;
   // Default width of the time-of-flight sample index.
   localparam int CNT_W_DEF = 16;

   // Detector states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_BLANK   = 3'd1,
      ST_SEARCH  = 3'd2,
      ST_CONFIRM = 3'd3,
      ST_HOLD    = 3'd4
   } eed_state_e;

endpackage

// File: rtl/energy_echo_detect.sv
// Energy-based echo detector with time-of-flight measurement.
// After a transmit burst (startPulse) each energy sample gets an index starting
// at 0. Samples inside the ring-down blank are ignored; afterwards a sample at or
// above threshOn opens a candidate, which becomes an echo once CONFIRM
// consecutive samples stay at or above threshOff. The echo is then tracked until
// energy drops below threshOff, reporting its peak. A window with no echo ends
// in a timeout pulse.
// Ports:
//   SYS_CLK, RESET          clock, synchronous active-high reset
//   startPulse              begin (or restart) a time-of-flight window
//   energyValid, inEnergy   energy sample strobe and value (unsigned)
//   threshOn, threshOff     onset / release thresholds (unsigned)
//   blankSamples            samples ignored after start
//   timeoutSamples          window length in samples
//   busy                    detector not idle
//   tofValid, tofCount      one-cycle echo pulse, onset sample index
//   timeout                 one-cycle pulse: window expired without echo
//   peakEnergy, peakDone    echo peak and its one-cycle completion pulse
module energy_echo_detect
   import energy_echo_detect_pkg::*;
#(
   parameter int E_W     = E_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int CONFIRM = 4
) (
   input  logic             SYS_CLK,
   input  logic             RESET,
   input  logic             startPulse,
   input  logic             energyValid,
   input  logic [E_W-1:0]   inEnergy,
   input  logic [E_W-1:0]   threshOn,
   input  logic [E_W-1:0]   threshOff,
   input  logic [CNT_W-1:0] blankSamples,
   input  logic [CNT_W-1:0] timeoutSamples,
   output logic             busy,
   output logic             tofValid,
   output logic [CNT_W-1:0] tofCount,
   output logic             timeout,
   output logic [E_W-1:0]   peakEnergy,
   output logic             peakDone
);

   localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM);
   localparam logic [CNT_W-1:0] IDX_MAX_C = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] IDX_ONE_C = CNT_W'(1);

   eed_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0] idx_r;
   logic [CNT_W-1:0] cand_r, cand_nxt_s;
   logic [3:0]       run_r, run_nxt_s, run_inc_s;
   logic [E_W-1:0]   peak_r, peak_nxt_s, peak_max_s;
   logic             ge_on_s, ge_off_s, tmo_hit_s;
   logic             declare_s, tmo_s, done_s;
   logic             busy_r, tof_valid_r, timeout_r, peak_done_r;
   logic [CNT_W-1:0] tof_count_r;
   logic [E_W-1:0]   peak_energy_r;

   assign ge_on_s    = (inEnergy >= threshOn);
   assign ge_off_s   = (inEnergy >= threshOff);
   assign tmo_hit_s  = (idx_r >= timeoutSamples);
   assign peak_max_s = (inEnergy > peak_r) ? inEnergy : peak_r;
   assign run_inc_s  = run_r + 4'd1;

   // Next-state and datapath update decisions for the current cycle.
   always_comb begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
      cand_nxt_s  = cand_r;
      peak_nxt_s  = peak_r;
      declare_s   = 1'b0;
      tmo_s       = 1'b0;
      done_s      = 1'b0;
      if (startPulse) begin
         // Restart wins over everything; a coincident sample is dropped.
         state_nxt_s = (blankSamples != {CNT_W{1'b0}}) ? ST_BLANK : ST_SEARCH;
         run_nxt_s   = 4'd0;
      end else if (energyValid) begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s = ST_IDLE;
            end
            ST_BLANK: begin
               if (tmo_hit_s) begin
                  tmo_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else if (idx_r == (blankSamples - IDX_ONE_C)) begin
                  state_nxt_s = ST_SEARCH;
               end else begin
                  state_nxt_s = ST_BLANK;
               end
            end
            ST_SEARCH: begin
               if (tmo_hit_s) begin
                  tmo_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else if (ge_on_s) begin
                  cand_nxt_s = idx_r;
                  run_nxt_s  = 4'd1;
                  peak_nxt_s = inEnergy;
                  if (CONFIRM_C == 4'd1) begin
                     declare_s   = 1'b1;
                     state_nxt_s = ST_HOLD;
                  end else begin
                     state_nxt_s = ST_CONFIRM;
                  end
               end else begin
                  state_nxt_s = ST_SEARCH;
               end
            end
            ST_CONFIRM: begin
               if (tmo_hit_s) begin
                  tmo_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else if (ge_off_s) begin
                  run_nxt_s  = run_inc_s;
                  peak_nxt_s = peak_max_s;
                  if (run_inc_s == CONFIRM_C) begin
                     declare_s   = 1'b1;
                     state_nxt_s = ST_HOLD;
                  end else begin
                     state_nxt_s = ST_CONFIRM;
                  end
               end else begin
                  run_nxt_s   = 4'd0;
                  state_nxt_s = ST_SEARCH;
               end
            end
            ST_HOLD: begin
               // Window timeout no longer applies once an echo is declared.
               if (ge_off_s) begin
                  peak_nxt_s  = peak_max_s;
                  state_nxt_s = ST_HOLD;
               end else begin
                  done_s      = 1'b1;
                  state_nxt_s = ST_IDLE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, counters, peak tracking and registered outputs.
   always_ff @(posedge SYS_CLK) begin
      if (RESET) begin
         state_r       <= ST_IDLE;
         idx_r         <= {CNT_W{1'b0}};
         run_r         <= 4'd0;
         cand_r        <= {CNT_W{1'b0}};
         peak_r        <= {E_W{1'b0}};
         busy_r        <= 1'b0;
         tof_valid_r   <= 1'b0;
         tof_count_r   <= {CNT_W{1'b0}};
         timeout_r     <= 1'b0;
         peak_done_r   <= 1'b0;
         peak_energy_r <= {E_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         run_r       <= run_nxt_s;
         cand_r      <= cand_nxt_s;
         peak_r      <= peak_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         tof_valid_r <= declare_s;
         timeout_r   <= tmo_s;
         peak_done_r <= done_s;
         // Index names the sample being presented; it saturates at all-ones.
         if (startPulse) begin
            idx_r <= {CNT_W{1'b0}};
         end else if (energyValid && (state_r != ST_IDLE) && (idx_r != IDX_MAX_C)) begin
            idx_r <= idx_r + IDX_ONE_C;
         end else begin
            idx_r <= idx_r;
         end
         if (declare_s) begin
            tof_count_r <= cand_nxt_s;
         end else begin
            tof_count_r <= tof_count_r;
         end
         // The sample that ends the echo is below threshOff, so it never
         // contributes to the reported peak.
         if (done_s) begin
            peak_energy_r <= peak_r;
         end else begin
            peak_energy_r <= peak_energy_r;
         end
      end
   end

   assign busy       = busy_r;
   assign tofValid   = tof_valid_r;
   assign tofCount   = tof_count_r;
   assign timeout    = timeout_r;
   assign peakEnergy = peak_energy_r;
   assign peakDone   = peak_done_r;

endmodule

// File: tb/tb_energy_echo_detect.sv
// Scoreboard bench for energy_echo_detect: two instances (CONFIRM=4 and
// CONFIRM=1) share one stimulus stream; a sample-level reference model predicts
// the pulse sequence of each, and monitors pop and compare on every pulse.
module tb_energy_echo_detect;

   localparam int EW = 24;
   localparam int CW = 16;
   localparam int K_TOF = 0;
   localparam int K_TMO = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int kind;
      int val;
   } evt_t;

   logic          SYS_CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          startPulse = 1'b0;
   logic          energyValid = 1'b0;
   logic [EW-1:0] inEnergy = '0;
   logic [EW-1:0] threshOn = '0;
   logic [EW-1:0] threshOff = '0;
   logic [CW-1:0] blankSamples = '0;
   logic [CW-1:0] timeoutSamples = '0;

   logic          busy4, tofValid4, timeout4, peakDone4;
   logic [CW-1:0] tofCount4;
   logic [EW-1:0] peakEnergy4;
   logic          busy1, tofValid1, timeout1, peakDone1;
   logic [CW-1:0] tofCount1;
   logic [EW-1:0] peakEnergy1;

   evt_t q4[$];
   evt_t q1[$];
   int   e[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cfg_blank, cfg_tmo, cfg_on, cfg_off;

   energy_echo_detect #(.E_W(EW), .CNT_W(CW), .CONFIRM(4)) dut4 (
      .SYS_CLK(SYS_CLK), .RESET(RESET), .startPulse(startPulse),
      .energyValid(energyValid), .inEnergy(inEnergy), .threshOn(threshOn),
      .threshOff(threshOff), .blankSamples(blankSamples),
      .timeoutSamples(timeoutSamples), .busy(busy4), .tofValid(tofValid4),
      .tofCount(tofCount4), .timeout(timeout4), .peakEnergy(peakEnergy4),
      .peakDone(peakDone4));

   energy_echo_detect #(.E_W(EW), .CNT_W(CW), .CONFIRM(1)) dut1 (
      .SYS_CLK(SYS_CLK), .RESET(RESET), .startPulse(startPulse),
      .energyValid(energyValid), .inEnergy(inEnergy), .threshOn(threshOn),
      .threshOff(threshOff), .blankSamples(blankSamples),
      .timeoutSamples(timeoutSamples), .busy(busy1), .tofValid(tofValid1),
      .tofCount(tofCount1), .timeout(timeout1), .peakEnergy(peakEnergy1),
      .peakDone(peakDone1));

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Pop the expected event for one instance and compare with what it showed.
   task automatic expect_evt(input int which, input int kind, input int val, input string nm);
      evt_t ex;
      int   sz;
      sz = (which == 4) ? q4.size() : q1.size();
      if (sz == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: unexpected pulse kind %0d value %0d, nothing expected", nm, kind, val);
      end else begin
         if (which == 4) ex = q4.pop_front();
         else            ex = q1.pop_front();
         chk(nm, longint'(kind) * 64'd33554432 + longint'(val),
                 longint'(ex.kind) * 64'd33554432 + longint'(ex.val));
      end
   endtask

   // Monitors: every output pulse must match the next predicted event.
   always @(negedge SYS_CLK) begin
      if (tofValid4) expect_evt(4, K_TOF, int'(tofCount4), "d4_event");
      if (timeout4)  expect_evt(4, K_TMO, 0, "d4_event");
      if (peakDone4) expect_evt(4, K_DONE, int'(peakEnergy4), "d4_event");
      if (tofValid1) expect_evt(1, K_TOF, int'(tofCount1), "d1_event");
      if (timeout1)  expect_evt(1, K_TMO, 0, "d1_event");
      if (peakDone1) expect_evt(1, K_DONE, int'(peakEnergy1), "d1_event");
   end

   task automatic push_evt(input int which, input int kind, input int val);
      evt_t ev;
      ev.kind = kind;
      ev.val  = val;
      if (which == 4) q4.push_back(ev);
      else            q1.push_back(ev);
   endtask

   // Reference: scan the sample list of one window by the detection rules and
   // predict the pulses; 'finished' tells whether the window ended in the run.
   task automatic model(input int c, input int which, output bit finished);
      int  n, i, j, k, run, pk;
      bit  stop;
      n = e.size();
      finished = 1'b0;
      stop = 1'b0;
      i = (cfg_blank < cfg_tmo) ? cfg_blank : cfg_tmo;
      while (i < n && !stop) begin
         if (i >= cfg_tmo) begin
            push_evt(which, K_TMO, 0);
            finished = 1'b1;
            stop = 1'b1;
         end else if (e[i] >= cfg_on) begin
            run = 1;
            pk = e[i];
            j = i + 1;
            while (run < c && j < n && j < cfg_tmo && e[j] >= cfg_off) begin
               if (e[j] > pk) pk = e[j];
               run++;
               j++;
            end
            if (run == c) begin
               push_evt(which, K_TOF, i);
               k = j;
               while (k < n && e[k] >= cfg_off) begin
                  if (e[k] > pk) pk = e[k];
                  k++;
               end
               if (k < n) begin
                  push_evt(which, K_DONE, pk);
                  finished = 1'b1;
               end
               stop = 1'b1;
            end else if (j >= n) begin
               stop = 1'b1;
            end else if (j >= cfg_tmo) begin
               push_evt(which, K_TMO, 0);
               finished = 1'b1;
               stop = 1'b1;
            end else begin
               i = j + 1;
            end
         end else begin
            i++;
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy4"}, busy4, 0);
      chk({tag, "_tof4"}, tofValid4, 0);
      chk({tag, "_cnt4"}, tofCount4, 0);
      chk({tag, "_tmo4"}, timeout4, 0);
      chk({tag, "_peak4"}, peakEnergy4, 0);
      chk({tag, "_done4"}, peakDone4, 0);
      chk({tag, "_busy1"}, busy1, 0);
      chk({tag, "_tof1"}, tofValid1, 0);
      chk({tag, "_done1"}, peakDone1, 0);
      chk({tag, "_peak1"}, peakEnergy1, 0);
   endtask

   // Run one window: predict, pulse start, feed samples, then audit the end state.
   task automatic run_window(input string tag, input bit coincident, input int max_gap);
      bit fin4, fin1;
      blankSamples   = CW'(cfg_blank);
      timeoutSamples = CW'(cfg_tmo);
      threshOn       = EW'(cfg_on);
      threshOff      = EW'(cfg_off);
      model(4, 4, fin4);
      model(1, 1, fin1);
      @(negedge SYS_CLK);
      startPulse  = 1'b1;
      energyValid = coincident;
      inEnergy    = EW'(cfg_on + 7);
      @(negedge SYS_CLK);
      startPulse  = 1'b0;
      energyValid = 1'b0;
      for (int s = 0; s < e.size(); s++) begin
         energyValid = 1'b1;
         inEnergy    = EW'(e[s]);
         @(negedge SYS_CLK);
         energyValid = 1'b0;
         inEnergy    = EW'($urandom_range(0, 3000));
         repeat ($urandom_range(0, max_gap)) @(negedge SYS_CLK);
      end
      repeat (3) @(negedge SYS_CLK);
      chk({tag, "_busy4"}, busy4, !fin4);
      chk({tag, "_busy1"}, busy1, !fin1);
      chk({tag, "_left4"}, q4.size(), 0);
      chk({tag, "_left1"}, q1.size(), 0);
      q4.delete();
      q1.delete();
   endtask

   task automatic fill(input int n, input int val);
      e.delete();
      for (int s = 0; s < n; s++) e.push_back(val);
   endtask

   initial begin
      int cat;
      repeat (3) @(negedge SYS_CLK);
      check_reset_state("reset");
      RESET = 1'b0;
      @(negedge SYS_CLK);

      // Nominal echo: onset 30, confirmed at 33, ends at 41.
      cfg_blank = 10; cfg_tmo = 100; cfg_on = 1000; cfg_off = 500;
      fill(45, 0);
      for (int s = 30; s <= 40; s++) e[s] = 2000;
      run_window("nominal", 1'b0, 2);

      // Energy only inside the blank: timeout on sample 100.
      fill(101, 0);
      for (int s = 0; s <= 9; s++) e[s] = 2000;
      run_window("blanked", 1'b0, 1);

      // Short burst dropped, second candidate confirmed.
      fill(30, 0);
      for (int s = 20; s <= 22; s++) e[s] = 2000;
      for (int s = 24; s <= 27; s++) e[s] = 600;
      e[24] = 2000;
      run_window("recand", 1'b0, 1);

      // Abort while confirming, restart carries a discarded sample.
      fill(51, 0);
      for (int s = 48; s <= 50; s++) e[s] = 2000;
      run_window("abort", 1'b0, 0);
      fill(45, 0);
      for (int s = 30; s <= 40; s++) e[s] = 2000;
      run_window("restart", 1'b1, 0);

      // Reset while holding an echo: silent abandon.
      fill(37, 0);
      for (int s = 30; s <= 40; s++) if (s < 37) e[s] = 2000;
      run_window("prehold", 1'b0, 0);
      RESET = 1'b1;
      @(negedge SYS_CLK);
      RESET = 1'b0;
      check_reset_state("hold_rst");
      repeat (5) begin
         energyValid = 1'b1;
         inEnergy    = EW'(5000);
         @(negedge SYS_CLK);
      end
      energyValid = 1'b0;
      @(negedge SYS_CLK);
      chk("idle_busy4", busy4, 0);
      chk("idle_busy1", busy1, 0);

      // No blank, onset exactly at threshOn on sample 0.
      cfg_blank = 0;
      fill(5, 0);
      e[0] = 1000;
      run_window("edge0", 1'b0, 0);

      // Randomized windows with sticky energy categories around the thresholds.
      for (int r = 0; r < 40; r++) begin
         cfg_off   = $urandom_range(100, 1000);
         cfg_on    = cfg_off + $urandom_range(0, 1000);
         cfg_blank = $urandom_range(0, 20);
         cfg_tmo   = $urandom_range(5, 60);
         e.delete();
         cat = 0;
         for (int s = 0; s < $urandom_range(1, 70); s++) begin
            if ($urandom_range(0, 9) < 3) cat = $urandom_range(0, 4);
            case (cat)
               0: e.push_back($urandom_range(0, cfg_off - 1));
               1: e.push_back($urandom_range(cfg_off, cfg_on));
               2: e.push_back($urandom_range(cfg_on, cfg_on + 5000));
               3: e.push_back(cfg_off);
               default: e.push_back(cfg_on);
            endcase
         end
         run_window("rand", ($urandom_range(0, 3) == 0), 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
